// File: rtl/falafel_pkg.sv
// Shared types and address map for the allocator host front end.
// Optional statistics counters in falafel_req_decoder are enabled by
// defining FALAFEL_DECODER_STATS_EN.
package falafel_pkg;

  localparam int PKG_DATA_W = 32;

  // Config register addresses
  localparam logic [PKG_DATA_W-1:0] FREE_LIST_PTR_ADDR = 32'h0000_0000;
  localparam logic [PKG_DATA_W-1:0] LOCK_PTR_ADDR      = 32'h0000_0004;
  localparam logic [PKG_DATA_W-1:0] LOCK_ID_ADDR       = 32'h0000_0008;

  // Command addresses, routed to the command FIFO
  localparam logic [PKG_DATA_W-1:0] ALLOC_CMD_ADDR     = 32'h0000_0010;
  localparam logic [PKG_DATA_W-1:0] FREE_CMD_ADDR      = 32'h0000_0014;

  typedef enum logic {
    CMD_ALLOC = 1'b0,
    CMD_FREE  = 1'b1
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e               kind;
    logic [PKG_DATA_W-1:0]   payload;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } req_dec_state_e;

  typedef enum logic [1:0] {
    CLS_BAD = 2'd0,
    CLS_CFG = 2'd1,
    CLS_CMD = 2'd2
  } addr_class_e;

  function automatic addr_class_e classify_addr(logic [PKG_DATA_W-1:0] addr);
    addr_class_e cls;
    cls = CLS_BAD;
    if (addr == FREE_LIST_PTR_ADDR || addr == LOCK_PTR_ADDR || addr == LOCK_ID_ADDR)
      cls = CLS_CFG;
    else if (addr == ALLOC_CMD_ADDR || addr == FREE_CMD_ADDR)
      cls = CLS_CMD;
    return cls;
  endfunction

endpackage

// File: rtl/falafel_cmd_fifo.sv
// Synchronous FIFO for allocator commands. Head output comes straight
// from storage flops; a full FIFO refuses a push even when a pop happens
// in the same cycle (no bypass path).
module falafel_cmd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign valid_o = ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers (wrap modulo DEPTH) and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/falafel_req_decoder.sv
// Host request decoder: splits requests into config-register write strobes
// and allocator commands (queued in falafel_cmd_fifo). A config write is
// held until the command queue is empty and the core is idle.
// Define FALAFEL_DECODER_STATS_EN to add saturating per-class counters.
//
// state  | meaning
// IDLE   | accepting requests
// DRAIN  | config latched, waiting for empty FIFO and idle core
// COMMIT | cfg_write_o asserted for this single cycle
module falafel_req_decoder
  import falafel_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              cfg_write_o,
  output logic [DATA_W-1:0] cfg_addr_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output cmd_t              cmd_o,
  input  logic              core_busy_i,
  output logic              err_o,
  input  logic              err_clr_i
`ifdef FALAFEL_DECODER_STATS_EN
  ,
  output logic [DATA_W-1:0] stat_alloc_o,
  output logic [DATA_W-1:0] stat_free_o,
  output logic [DATA_W-1:0] stat_bad_o
`endif
);

  localparam int CMD_W = $bits(cmd_t);

  req_dec_state_e    state_q;
  logic              cfg_write_q;
  logic [DATA_W-1:0] cfg_addr_q, cfg_data_q;
  logic              err_q;
  addr_class_e       cls;
  logic              accept, push, pop, fifo_full, fifo_empty, can_commit;
  cmd_t              push_cmd;
  logic [CMD_W-1:0]  fifo_head;

  assign cls         = classify_addr(req_addr_i);
  assign req_ready_o = (state_q == IDLE) && ((cls == CLS_CMD) ? !fifo_full : 1'b1);
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & (cls == CLS_CMD);
  assign pop         = cmd_valid_o & cmd_ready_i;
  assign can_commit  = fifo_empty & ~core_busy_i;

  // Build the command pushed for a CMD-class request
  always_comb begin
    push_cmd         = '0;
    push_cmd.kind    = (req_addr_i == FREE_CMD_ADDR) ? CMD_FREE : CMD_ALLOC;
    push_cmd.payload = req_data_i;
  end

  falafel_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_cmd),
    .pop_i       (pop),
    .valid_o     (cmd_valid_o),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_o       = cmd_t'(fifo_head);
  assign cfg_write_o = cfg_write_q;
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_data_o  = cfg_data_q;
  assign err_o       = err_q;

  // Config write sequencing; the strobe is registered alongside the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cfg_write_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      cfg_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && cls == CLS_CFG) begin
            cfg_addr_q <= req_addr_i;
            cfg_data_q <= req_data_i;
            if (can_commit) begin
              state_q     <= COMMIT;
              cfg_write_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (can_commit) begin
            state_q     <= COMMIT;
            cfg_write_q <= 1'b1;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error on unmapped address; a new error beats a clear
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (accept && cls == CLS_BAD) err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

`ifdef FALAFEL_DECODER_STATS_EN
  logic [DATA_W-1:0] stat_alloc_q, stat_free_q, stat_bad_q;

  // Saturating per-class counters of accepted requests
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_alloc_q <= '0;
      stat_free_q  <= '0;
      stat_bad_q   <= '0;
    end else if (accept) begin
      if (push && push_cmd.kind == CMD_ALLOC && stat_alloc_q != '1)
        stat_alloc_q <= stat_alloc_q + 1'b1;
      if (push && push_cmd.kind == CMD_FREE && stat_free_q != '1)
        stat_free_q <= stat_free_q + 1'b1;
      if (cls == CLS_BAD && stat_bad_q != '1)
        stat_bad_q <= stat_bad_q + 1'b1;
    end
  end

  assign stat_alloc_o = stat_alloc_q;
  assign stat_free_o  = stat_free_q;
  assign stat_bad_o   = stat_bad_q;
`endif

endmodule
